// File: rtl/wta_arbiter_h1_pkg.sv
// Shared constants and FSM state type for the hidden-layer-1 winner-take-all arbiter.
package wta_arbiter_h1_pkg;

    localparam int unsigned N2    = 8;
    localparam int unsigned POT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_SCAN,
        ST_ISSUE
    } wta_state_e;

endpackage

// File: rtl/wta_arbiter_h1_max_scan.sv
// Sequential signed max search over N candidates, one per cycle, seeded with the threshold.
module wta_max_scan
    import wta_arbiter_h1_pkg::*;
#(
    parameter int unsigned N  = N2,
    parameter int unsigned W  = POT_W,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                start,
    input  logic signed [W-1:0] threshold,
    input  logic signed [W-1:0] cand_val,
    output logic [IW-1:0]       scan_idx,
    output logic [IW-1:0]       best_idx,
    output logic                best_found,
    output logic                done
);

    logic                active_q, active_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic signed [W-1:0] best_val_q, best_val_d;
    logic [IW-1:0]       best_idx_q, best_idx_d;
    logic                best_found_q, best_found_d;
    logic                done_q, done_d;

    always_comb begin
        active_d     = active_q;
        idx_d        = idx_q;
        best_val_d   = best_val_q;
        best_idx_d   = best_idx_q;
        best_found_d = best_found_q;
        done_d       = 1'b0;
        if (clear) begin
            active_d     = 1'b0;
            idx_d        = '0;
            best_found_d = 1'b0;
        end else if (start) begin
            active_d     = 1'b1;
            idx_d        = '0;
            best_val_d   = threshold;
            best_idx_d   = '0;
            best_found_d = 1'b0;
        end else if (active_q) begin
            // Strict compare: ties keep the earlier (lower) index, threshold itself never wins.
            if (cand_val > best_val_q) begin
                best_val_d   = cand_val;
                best_idx_d   = idx_q;
                best_found_d = 1'b1;
            end
            if (idx_q == IW'(N - 1)) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q     <= 1'b0;
            idx_q        <= '0;
            best_val_q   <= '0;
            best_idx_q   <= '0;
            best_found_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            active_q     <= active_d;
            idx_q        <= idx_d;
            best_val_q   <= best_val_d;
            best_idx_q   <= best_idx_d;
            best_found_q <= best_found_d;
            done_q       <= done_d;
        end
    end

    assign scan_idx   = idx_q;
    assign best_idx   = best_idx_q;
    assign best_found = best_found_q;
    assign done       = done_q;

endmodule

// File: rtl/wta_arbiter_h1.sv
// Winner-take-all arbiter for hidden layer 1: collects final potentials, picks the strongest
// neuron above threshold, and releases the adders with a single start_pp3m pulse.
module wta_arbiter_h1
    import wta_arbiter_h1_pkg::*;
#(
    parameter int unsigned N  = N2,
    parameter int unsigned W  = POT_W,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_core_img,
    input  logic signed [W-1:0] threshold,
    input  logic [N-1:0]        valid_pp3m,
    input  logic [N*W-1:0]      potential_bus,
    output logic                start_pp3m,
    output logic [N-1:0]        won_lost_hold,
    output logic                winner_valid,
    output logic [IW-1:0]       winner_idx,
    output logic                busy,
    output logic                overrun
);

    wta_state_e          state_q, state_d;
    logic [N-1:0]        flag_q, flag_d;
    logic signed [W-1:0] snap_q [N];
    logic signed [W-1:0] snap_d [N];
    logic                start_pp3m_q, start_pp3m_d;
    logic [N-1:0]        won_q, won_d;
    logic                winner_valid_q, winner_valid_d;
    logic [IW-1:0]       winner_idx_q, winner_idx_d;
    logic                overrun_q, overrun_d;

    logic                capture;
    logic                scan_start;
    logic [IW-1:0]       scan_idx;
    logic [IW-1:0]       best_idx;
    logic                best_found;
    logic                scan_done;

    wta_max_scan #(
        .N  (N),
        .W  (W),
        .IW (IW)
    ) u_max_scan (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_core_img),
        .start      (scan_start),
        .threshold  (threshold),
        .cand_val   (snap_q[scan_idx]),
        .scan_idx   (scan_idx),
        .best_idx   (best_idx),
        .best_found (best_found),
        .done       (scan_done)
    );

    always_comb begin
        state_d        = state_q;
        flag_d         = flag_q;
        snap_d         = snap_q;
        start_pp3m_d   = 1'b0;
        won_d          = won_q;
        winner_valid_d = 1'b0;
        winner_idx_d   = winner_idx_q;
        overrun_d      = overrun_q;
        capture        = 1'b0;
        scan_start     = 1'b0;

        if (start_core_img) begin
            state_d      = ST_IDLE;
            flag_d       = '0;
            won_d        = '1;
            winner_idx_d = '0;
            overrun_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    capture = 1'b1;
                    if (|valid_pp3m) state_d = ST_COLLECT;
                end
                ST_COLLECT: begin
                    if (&flag_q) begin
                        state_d    = ST_SCAN;
                        scan_start = 1'b1;
                    end else begin
                        capture = 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (|valid_pp3m) overrun_d = 1'b1;
                    // Outputs are registered on the ISSUE entry edge so they are live during ISSUE.
                    if (scan_done) begin
                        state_d      = ST_ISSUE;
                        start_pp3m_d = 1'b1;
                        if (best_found) begin
                            won_d          = '0;
                            won_d[best_idx] = 1'b1;
                            winner_valid_d = 1'b1;
                            winner_idx_d   = best_idx;
                        end else begin
                            won_d = '1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (|valid_pp3m) overrun_d = 1'b1;
                    flag_d  = '0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // First pulse per neuron wins; repeats keep the original snapshot.
        if (capture) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (valid_pp3m[i] && !flag_q[i]) begin
                    flag_d[i] = 1'b1;
                    snap_d[i] = $signed(potential_bus[i*W +: W]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            flag_q         <= '0;
            for (int unsigned i = 0; i < N; i++) snap_q[i] <= '0;
            start_pp3m_q   <= 1'b0;
            won_q          <= '1;
            winner_valid_q <= 1'b0;
            winner_idx_q   <= '0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            flag_q         <= flag_d;
            for (int unsigned i = 0; i < N; i++) snap_q[i] <= snap_d[i];
            start_pp3m_q   <= start_pp3m_d;
            won_q          <= won_d;
            winner_valid_q <= winner_valid_d;
            winner_idx_q   <= winner_idx_d;
            overrun_q      <= overrun_d;
        end
    end

    assign start_pp3m    = start_pp3m_q;
    assign won_lost_hold = won_q;
    assign winner_valid  = winner_valid_q;
    assign winner_idx    = winner_idx_q;
    assign busy          = (state_q != ST_IDLE);
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_wta_arbiter_h1.sv
// Self-checking bench for wta_arbiter_h1: table-driven rounds plus hand-written corner sequences.
module tb_wta_arbiter_h1;

    localparam int N  = 8;
    localparam int W  = 32;
    localparam int IW = 3;

    logic                clk;
    logic                rst;
    logic                start_core_img;
    logic signed [W-1:0] threshold;
    logic [N-1:0]        valid_pp3m;
    logic [N*W-1:0]      potential_bus;
    logic                start_pp3m;
    logic [N-1:0]        won_lost_hold;
    logic                winner_valid;
    logic [IW-1:0]       winner_idx;
    logic                busy;
    logic                overrun;

    wta_arbiter_h1 #(.N(N), .W(W), .IW(IW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_core_img (start_core_img),
        .threshold      (threshold),
        .valid_pp3m     (valid_pp3m),
        .potential_bus  (potential_bus),
        .start_pp3m     (start_pp3m),
        .won_lost_hold  (won_lost_hold),
        .winner_valid   (winner_valid),
        .winner_idx     (winner_idx),
        .busy           (busy),
        .overrun        (overrun)
    );

    typedef struct {
        string name;
        int    th;
        int    pot [N];
        int    off [N];
        bit    found;
        int    idx;
    } round_t;

    typedef struct {
        bit           found;
        int           idx;
        logic [N-1:0] won;
        int           e0;
    } exp_t;

    round_t rounds [6];
    exp_t   exp_q [$];
    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic logic [N-1:0] won_of(input bit found, input int idx);
        logic [N-1:0] w;
        w = '1;
        if (found) begin
            w = '0;
            w[idx] = 1'b1;
        end
        return w;
    endfunction

    // Scoreboard consumer: every start_pp3m pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && start_pp3m) begin
            if (exp_q.size() == 0) begin
                check("unexpected_start", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("latency", cyc, e.e0 + N + 2);
                check("winner_valid", winner_valid, e.found);
                if (e.found) check("winner_idx", winner_idx, e.idx);
                check("won_lost_hold", won_lost_hold, e.won);
            end
        end
    end

    task automatic push_exp(input bit found, input int idx, input int e0);
        exp_t e;
        e.found = found;
        e.idx   = idx;
        e.won   = won_of(found, idx);
        e.e0    = e0;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name, input logic [N-1:0] won_exp);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check({name, "_timeout"}, 64'(exp_q.size()), 0);
            exp_q.delete();
        end
        @(negedge clk);
        check({name, "_start_one_cycle"}, start_pp3m, 0);
        check({name, "_valid_one_cycle"}, winner_valid, 0);
        check({name, "_busy_after"}, busy, 0);
        check({name, "_hold_after"}, won_lost_hold, won_exp);
    endtask

    task automatic run_round(input round_t r);
        int last = 0;
        threshold = r.th;
        for (int i = 0; i < N; i++) begin
            potential_bus[i*W +: W] = r.pot[i];
            if (r.off[i] > last) last = r.off[i];
        end
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) valid_pp3m[i] = (r.off[i] == c);
        end
        push_exp(r.found, r.idx, cyc + 1);
        @(negedge clk);
        valid_pp3m = '0;
        wait_done(r.name, won_of(r.found, r.idx));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1);
    end

    initial begin
        round_t r;
        int starts;

        rounds[0] = '{"basic",   15017, '{0, 2000, 20000, 5000, 0, 0, 0, 0},
                      '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b1, 2};
        rounds[1] = '{"stagger", 15017, '{100, 200, 300, 30000, 400, 500, 30000, 600},
                      '{0, 1, 2, 4, 3, 1, 2, 0}, 1'b1, 3};
        rounds[2] = '{"nowin",   15017, '{15017, 0, -5, 15000, 1, 2, 3, 4},
                      '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 0};
        rounds[3] = '{"signed",  -100, '{-2048000, -2048000, -50, -2048000, -101, -100, -2048000, -2048000},
                      '{1, 0, 2, 0, 1, 0, 0, 1}, 1'b1, 2};
        rounds[4] = '{"last_idx", 0, '{-1, 0, 0, 0, 0, 0, 0, 1},
                      '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b1, 7};
        rounds[5] = '{"max_pos", 2147483646, '{2147483647, 2147483646, 2147483646, 2147483646,
                      2147483646, 2147483646, 2147483646, 2147483647},
                      '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b1, 0};

        rst            = 1'b1;
        start_core_img = 1'b0;
        threshold      = '0;
        valid_pp3m     = '0;
        potential_bus  = '0;
        repeat (2) @(negedge clk);
        check("rst_start", start_pp3m, 0);
        check("rst_won", won_lost_hold, 8'hFF);
        check("rst_wvalid", winner_valid, 0);
        check("rst_widx", winner_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 6; k++) run_round(rounds[k]);
        check("overrun_clean", overrun, 0);

        // Repeat pulse keeps first snapshot; pulse during SCAN flags overrun only.
        threshold = 15017;
        potential_bus = '0;
        potential_bus[1*W +: W] = 100;
        potential_bus[4*W +: W] = 20000;
        @(negedge clk); valid_pp3m = 8'h02;
        @(negedge clk); valid_pp3m = 8'h02; potential_bus[1*W +: W] = 50000;
        @(negedge clk); valid_pp3m = 8'hFD;
        push_exp(1'b1, 4, cyc + 1);
        @(negedge clk); valid_pp3m = '0;
        check("busy_in_round", busy, 1);
        @(negedge clk); valid_pp3m = 8'hFF; potential_bus[4*W +: W] = 0; potential_bus[6*W +: W] = 90000;
        @(negedge clk); valid_pp3m = '0;
        check("overrun_set", overrun, 1);
        wait_done("dup_overrun", won_of(1'b1, 4));
        check("overrun_sticky", overrun, 1);

        // Abort mid-SCAN: no start pulse, outputs back to reset values.
        potential_bus = '0;
        potential_bus[2*W +: W] = 20000;
        @(negedge clk); valid_pp3m = 8'hFF;
        @(negedge clk); valid_pp3m = '0;
        repeat (3) @(negedge clk);
        start_core_img = 1'b1;
        @(negedge clk); start_core_img = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_overrun", overrun, 0);
        check("abort_won", won_lost_hold, 8'hFF);
        check("abort_start", start_pp3m, 0);
        starts = 0;
        repeat (15) begin
            @(negedge clk);
            if (start_pp3m) starts++;
        end
        check("abort_no_start", starts, 0);

        run_round(rounds[0]);

        // Async reset in the middle of COLLECT.
        potential_bus = '0;
        potential_bus[0*W +: W] = 50000;
        @(negedge clk); valid_pp3m = 8'h01;
        @(negedge clk); valid_pp3m = '0;
        check("collect_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_start", start_pp3m, 0);
        check("arst_won", won_lost_hold, 8'hFF);
        check("arst_wvalid", winner_valid, 0);
        check("arst_widx", winner_idx, 0);
        check("arst_busy", busy, 0);
        check("arst_overrun", overrun, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // Flags must be clear after reset: neuron 0 is re-latched at a low value.
        r = '{"post_rst", 15017, '{100, 0, 0, 0, 0, 20000, 0, 0},
              '{1, 0, 0, 0, 0, 0, 0, 0}, 1'b1, 5};
        run_round(r);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wta_arbiter_h1.md
Name: wta_arbiter_h1

Overview:
Lateral-inhibition (winner-take-all) arbiter for hidden layer 1. It sits directly downstream of the N per-neuron potential adders. In pp3 mode it collects each neuron's valid_pp3m and integrated potential, then scans for the strongest neuron above threshold. It drives each neuron's won_lost_hold and issues the shared start_pp3m pulse that lets the adders finish the time unit.

Parameters:
N, 8, neurons in the layer (number of adders served)
W, 32, potential width, signed Q.12 fixed point
IW, 3, winner index width, ceil(log2(N))

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start_core_img  in  1  synchronous abort/clear at image start
threshold  in  W  signed firing threshold, same value the adders use
valid_pp3m  in  N  bit i: one-cycle pulse from adder i, potential i is final
potential_bus  in  N*W  potential of neuron i in bits [i*W +: W], signed
start_pp3m  out  1  one-cycle pulse to all adders
won_lost_hold  out  N  bit i = 1: neuron i evaluates normally; 0: inhibited
winner_valid  out  1  high with start_pp3m when a winner exists
winner_idx  out  IW  winner index; valid when winner_valid = 1
busy  out  1  high in any state other than IDLE
overrun  out  1  sticky error flag

Behaviour:
- Reset values: start_pp3m=0, won_lost_hold={N{1}}, winner_valid=0, winner_idx=0, busy=0, overrun=0. State=IDLE, collected flags=0.
- States: IDLE, COLLECT, SCAN, ISSUE.
- IDLE: any valid_pp3m bit moves the FSM to COLLECT. The same edge latches those flags and potentials.
- COLLECT: on each edge where valid_pp3m[i]=1, set flag[i] and latch potential_bus slice i into snap[i].
  - A repeat pulse for an already-set flag is ignored. The original snapshot is kept.
  - When all flags are set, go to SCAN: scan idx=0, best_val=threshold, best_found=0.
- SCAN: one neuron per cycle, idx 0..N-1.
  - If snap[idx] > best_val (signed, strict), then best_val=snap[idx], best_idx=idx, best_found=1.
  - Strict compare: a tie goes to the lowest index. A potential equal to threshold never wins.
  - After idx=N-1 is processed, go to ISSUE.
- ISSUE (one cycle, registered outputs):
  - start_pp3m=1.
  - If best_found: won_lost_hold = one-hot(best_idx), winner_valid=1, winner_idx=best_idx.
  - Otherwise: won_lost_hold = all ones, winner_valid=0.
  - Clear flags, return to IDLE.
- Output timing:
  - start_pp3m and winner_valid are high for exactly one cycle.
  - won_lost_hold is valid in the same cycle as start_pp3m and holds until the next ISSUE, start_core_img, or rst.
- Latency: the last valid_pp3m is sampled at edge E0. start_pp3m is high in the cycle after edge E0+N+2 (1 to enter SCAN, N scan steps, 1 to ISSUE).
- valid_pp3m in SCAN or ISSUE: ignored and overrun set. overrun clears only on rst or start_core_img.
- start_core_img (priority over all but rst):
  - State=IDLE, flags=0, outputs set to reset values except threshold (an input).
  - An in-flight round is abandoned; no start_pp3m is issued.
- Arithmetic: all compares are signed W-bit; no arithmetic is widened. threshold is sampled combinationally at the SCAN entry edge and held in best_val.

Decomposition:
- Shared header (existing header.vh): W, neuron count N2, state encodings for the arbiter FSM.
- One sub-module: wta_max_scan. It holds the sequential compare datapath (best_val, best_idx, best_found, idx counter) with start/done handshake. The parent keeps the collect flags, snapshot registers and output registers.

Test Plan:
- N=8, threshold=15017, all 8 valid_pp3m in one cycle, potentials {0,2000,20000,5000,0,0,0,0} -> start_pp3m pulse 11 cycles later, winner_idx=2, won_lost_hold=8'b00000100, winner_valid=1.
- Valids staggered over 5 cycles, neurons 3 and 6 both at 30000 -> winner_idx=3 (lowest index), latency counted from the last valid.
- All potentials ≤ threshold, one exactly = 15017 -> winner_valid=0, won_lost_hold=8'hFF, start_pp3m still pulses once.
- Negative potentials (-2048000) mixed with threshold=-100: neuron at -50 wins -> confirms signed compare.
- valid_pp3m[1] pulsed twice in COLLECT with a different potential -> first snapshot used. Pulse during SCAN -> overrun=1, result unaffected.
- start_core_img asserted mid-SCAN -> no start_pp3m, busy=0 next cycle, overrun=0, won_lost_hold=8'hFF. Async rst mid-COLLECT -> all reset values immediately.
